// File: rtl/regfile_write_sequencer_pkg.sv
// Shared widths, queue entry layout and occupancy sizing for the
// register-file write sequencer.
package regfile_write_sequencer_pkg;

    localparam int DW = 16;
    localparam int RW = 4;

    typedef struct packed {
        logic [RW-1:0] rid;
        logic [DW-1:0] data;
    } wb_entry_t;

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/regfile_write_sequencer_wb_fifo2in.sv
// Circular buffer with two ordered push ports (a before b) and one pop port.
// Exposes per-entry valid bits and register ids for hazard comparison.
module wb_fifo2in
    import regfile_write_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             srst,
    input  logic                             push_a,
    input  wb_entry_t                        entry_a,
    input  logic                             push_b,
    input  wb_entry_t                        entry_b,
    input  logic                             pop,
    output wb_entry_t                        head_entry,
    output logic [DEPTH-1:0]                 valid,
    output logic [DEPTH-1:0][RW-1:0]         rids,
    output logic [occ_width(DEPTH)-1:0]      count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = occ_width(DEPTH);

    logic [PW-1:0]    head_reg, tail_reg;
    logic [CW-1:0]    count_reg;
    logic [DEPTH-1:0] valid_reg;
    wb_entry_t        entry_reg [DEPTH];
    logic [PW-1:0]    idx_a, idx_b;

    // Port b lands behind port a only when a actually pushes this cycle.
    assign idx_a = tail_reg;
    assign idx_b = tail_reg + PW'(push_a);

    always_ff @(posedge clk) begin
        if (srst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_reg + PW'(pop);
            tail_reg  <= tail_reg + PW'(push_a) + PW'(push_b);
            count_reg <= count_reg + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (srst) begin
                    valid_reg[gi] <= 1'b0;
                end else if ((push_a && idx_a == PW'(gi)) || (push_b && idx_b == PW'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end else if (pop && head_reg == PW'(gi)) begin
                    valid_reg[gi] <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (push_a && idx_a == PW'(gi)) begin
                    entry_reg[gi] <= entry_a;
                end else if (push_b && idx_b == PW'(gi)) begin
                    entry_reg[gi] <= entry_b;
                end
            end

            assign rids[gi] = entry_reg[gi].rid;
        end
    endgenerate

    assign head_entry = entry_reg[head_reg];
    assign valid      = valid_reg;
    assign count      = count_reg;

endmodule

// File: rtl/regfile_write_sequencer.sv
// Merges MEM and ALU writebacks in program order into the single register
// file write port, one commit per cycle, and flags pending source registers.
module regfile_write_sequencer
    import regfile_write_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_valid,
    input  logic [RW-1:0]                mem_reg,
    input  logic [DW-1:0]                mem_data,
    output logic                         mem_ready,
    input  logic                         alu_valid,
    input  logic [RW-1:0]                alu_reg,
    input  logic [DW-1:0]                alu_data,
    output logic                         alu_ready,
    output logic                         rf_wen,
    output logic [RW-1:0]                rf_reg,
    output logic [DW-1:0]                rf_data,
    input  logic [RW-1:0]                src_reg1,
    input  logic [RW-1:0]                src_reg2,
    output logic                         pend1,
    output logic                         pend2,
    output logic [occ_width(DEPTH)-1:0]  count
);

    localparam int CW = occ_width(DEPTH);

    logic [CW-1:0]           free;
    logic                    push_mem, push_alu, pop;
    wb_entry_t               mem_entry, alu_entry, head_entry;
    logic [DEPTH-1:0]        valid;
    logic [DEPTH-1:0][RW-1:0] rids;
    logic [DEPTH-1:0]        match1, match2;
    logic                    rf_wen_reg;
    logic [RW-1:0]           rf_reg_reg;
    logic [DW-1:0]           rf_data_reg;

    assign free = CW'(DEPTH) - count;

    // ALU needs a second free slot whenever the older MEM write is also asking.
    assign mem_ready = (free >= CW'(1));
    assign alu_ready = mem_valid ? (free >= CW'(2)) : (free >= CW'(1));
    assign push_mem  = mem_valid && mem_ready;
    assign push_alu  = alu_valid && alu_ready;
    assign pop       = (count != '0);

    assign mem_entry = '{rid: mem_reg, data: mem_data};
    assign alu_entry = '{rid: alu_reg, data: alu_data};

    wb_fifo2in #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (rst),
        .push_a    (push_mem),
        .entry_a   (mem_entry),
        .push_b    (push_alu),
        .entry_b   (alu_entry),
        .pop       (pop),
        .head_entry(head_entry),
        .valid     (valid),
        .rids      (rids),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen_reg  <= 1'b0;
            rf_reg_reg  <= '0;
            rf_data_reg <= '0;
        end else begin
            rf_wen_reg <= pop;
            if (pop) begin
                rf_reg_reg  <= head_entry.rid;
                rf_data_reg <= head_entry.data;
            end
        end
    end

    assign rf_wen  = rf_wen_reg;
    assign rf_reg  = rf_reg_reg;
    assign rf_data = rf_data_reg;

    // The entry on the write port is still uncommitted until the next edge.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match1[gi] = valid[gi] && (rids[gi] == src_reg1);
            assign match2[gi] = valid[gi] && (rids[gi] == src_reg2);
        end
    endgenerate

    assign pend1 = (|match1) || (rf_wen_reg && rf_reg_reg == src_reg1);
    assign pend2 = (|match2) || (rf_wen_reg && rf_reg_reg == src_reg2);

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed table-driven bench for the register-file write sequencer,
// followed by a hand-written latency sequence.
module tb_regfile_write_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, alu_valid;
    logic [3:0]  mem_reg, alu_reg, src_reg1, src_reg2;
    logic [15:0] mem_data, alu_data;
    logic        mem_ready, alu_ready, rf_wen, pend1, pend2;
    logic [3:0]  rf_reg;
    logic [15:0] rf_data;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_write_sequencer #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_valid(mem_valid),
        .mem_reg  (mem_reg),
        .mem_data (mem_data),
        .mem_ready(mem_ready),
        .alu_valid(alu_valid),
        .alu_reg  (alu_reg),
        .alu_data (alu_data),
        .alu_ready(alu_ready),
        .rf_wen   (rf_wen),
        .rf_reg   (rf_reg),
        .rf_data  (rf_data),
        .src_reg1 (src_reg1),
        .src_reg2 (src_reg2),
        .pend1    (pend1),
        .pend2    (pend2),
        .count    (count)
    );

    typedef struct {
        logic        rst;
        logic        mv;
        logic [3:0]  mr;
        logic [15:0] md;
        logic        av;
        logic [3:0]  ar;
        logic [15:0] ad;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        e_wen;
        logic [3:0]  e_reg;
        logic [15:0] e_data;
        logic [2:0]  e_cnt;
        logic        e_mrdy;
        logic        e_ardy;
        logic        e_p1;
        logic        e_p2;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic mv, input logic [3:0] mr, input logic [15:0] md,
                       input logic av, input logic [3:0] ar, input logic [15:0] ad,
                       input logic [3:0] s1, input logic [3:0] s2,
                       input logic ew, input logic [3:0] er, input logic [15:0] ed, input logic [2:0] ec,
                       input logic emr, input logic ear, input logic ep1, input logic ep2);
        vec_t v;
        v = '{r, mv, mr, md, av, ar, ad, s1, s2, ew, er, ed, ec, emr, ear, ep1, ep2};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    endtask

    initial begin
        int  edges;
        bit  seen;

        rst = 1'b1;
        src_reg1 = '0;
        src_reg2 = '0;
        drive_idle();

        //   rst mv mr   md       av ar   ad       s1   s2    wen reg  data     cnt mr ar p1 p2
        add(1, 1, 4'h3, 16'hAAAA, 1, 4'h4, 16'hBBBB, 4'h3, 4'h4, 0, 4'h0, 16'h0000, 0, 1, 1, 0, 0);
        add(1, 1, 4'h3, 16'hAAAA, 1, 4'h4, 16'hBBBB, 4'h3, 4'h4, 0, 4'h0, 16'h0000, 0, 1, 1, 0, 0);
        add(0, 1, 4'h3, 16'hBEEF, 0, 4'h0, 16'h0000, 4'h3, 4'h0, 0, 4'h0, 16'h0000, 0, 1, 1, 0, 0);
        add(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h3, 4'h0, 0, 4'h0, 16'h0000, 1, 1, 1, 1, 0);
        add(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h3, 4'h0, 1, 4'h3, 16'hBEEF, 0, 1, 1, 1, 0);
        add(0, 1, 4'h5, 16'h1111, 1, 4'h5, 16'h2222, 4'h5, 4'h3, 0, 4'h3, 16'hBEEF, 0, 1, 1, 0, 0);
        add(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h5, 4'h3, 0, 4'h3, 16'hBEEF, 2, 1, 1, 1, 0);
        add(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h5, 4'h3, 1, 4'h5, 16'h1111, 1, 1, 1, 1, 0);
        add(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h5, 4'h3, 1, 4'h5, 16'h2222, 0, 1, 1, 1, 0);
        add(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h5, 4'h3, 0, 4'h5, 16'h2222, 0, 1, 1, 0, 0);
        add(0, 1, 4'h1, 16'h0101, 1, 4'h2, 16'h0202, 4'h1, 4'h2, 0, 4'h5, 16'h2222, 0, 1, 1, 0, 0);
        add(0, 1, 4'h3, 16'h0303, 1, 4'h4, 16'h0404, 4'h1, 4'h2, 0, 4'h5, 16'h2222, 2, 1, 1, 1, 1);
        add(0, 1, 4'h6, 16'h0606, 1, 4'h7, 16'h0707, 4'h1, 4'h2, 1, 4'h1, 16'h0101, 3, 1, 0, 1, 1);
        add(0, 0, 4'h0, 16'h0000, 1, 4'h7, 16'h0707, 4'h3, 4'h7, 1, 4'h2, 16'h0202, 3, 1, 1, 1, 0);
        add(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h3, 4'h7, 1, 4'h3, 16'h0303, 3, 1, 1, 1, 1);
        add(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h4, 4'h6, 1, 4'h4, 16'h0404, 2, 1, 1, 1, 1);
        add(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h6, 4'h7, 1, 4'h6, 16'h0606, 1, 1, 1, 1, 1);
        add(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h7, 4'h2, 1, 4'h7, 16'h0707, 0, 1, 1, 1, 0);
        add(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h7, 4'h2, 0, 4'h7, 16'h0707, 0, 1, 1, 0, 0);
        add(0, 1, 4'h8, 16'h0808, 1, 4'h9, 16'h0909, 4'h8, 4'h9, 0, 4'h7, 16'h0707, 0, 1, 1, 0, 0);
        add(0, 1, 4'hA, 16'h0A0A, 1, 4'hB, 16'h0B0B, 4'h8, 4'h9, 0, 4'h7, 16'h0707, 2, 1, 1, 1, 1);
        add(1, 1, 4'hC, 16'h0C0C, 1, 4'hD, 16'h0D0D, 4'h9, 4'hB, 1, 4'h8, 16'h0808, 3, 1, 0, 1, 1);
        add(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h9, 4'hB, 0, 4'h0, 16'h0000, 0, 1, 1, 0, 0);
        add(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h8, 4'hA, 0, 4'h0, 16'h0000, 0, 1, 1, 0, 0);

        @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            #1;
            rst = vecs[i].rst;
            mem_valid = vecs[i].mv; mem_reg = vecs[i].mr; mem_data = vecs[i].md;
            alu_valid = vecs[i].av; alu_reg = vecs[i].ar; alu_data = vecs[i].ad;
            src_reg1 = vecs[i].s1;  src_reg2 = vecs[i].s2;
            #3;
            $display("step %0d rst=%0b mem=%0b:%0h/%h alu=%0b:%0h/%h -> wen=%0b reg=%0h data=%h cnt=%0d rdy=%0b%0b pend=%0b%0b",
                     i, rst, mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
                     rf_wen, rf_reg, rf_data, count, mem_ready, alu_ready, pend1, pend2);
            check("rf_wen",    i, 32'(rf_wen),    32'(vecs[i].e_wen));
            check("rf_reg",    i, 32'(rf_reg),    32'(vecs[i].e_reg));
            check("rf_data",   i, 32'(rf_data),   32'(vecs[i].e_data));
            check("count",     i, 32'(count),     32'(vecs[i].e_cnt));
            check("mem_ready", i, 32'(mem_ready), 32'(vecs[i].e_mrdy));
            check("alu_ready", i, 32'(alu_ready), 32'(vecs[i].e_ardy));
            check("pend1",     i, 32'(pend1),     32'(vecs[i].e_p1));
            check("pend2",     i, 32'(pend2),     32'(vecs[i].e_p2));
            @(posedge clk);
        end

        // ALU-only write into an empty queue: it must reach the write port
        // exactly one edge after the accepting edge.
        #1;
        rst = 1'b0;
        drive_idle();
        alu_valid = 1'b1; alu_reg = 4'hE; alu_data = 16'hCAFE;
        src_reg1 = 4'hE; src_reg2 = 4'h1;
        #3;
        check("lat_alu_ready", 100, 32'(alu_ready), 32'd1);
        @(posedge clk);
        #1;
        drive_idle();
        #3;
        check("lat_pend1_queued", 100, 32'(pend1), 32'd1);
        check("lat_count", 100, 32'(count), 32'd1);
        edges = 0;
        seen  = 1'b0;
        while (edges < 6 && !seen) begin
            @(posedge clk);
            #1;
            edges++;
            if (rf_wen) seen = 1'b1;
        end
        $display("step lat alu=e:cafe -> wen=%0b reg=%0h data=%h after %0d edges", rf_wen, rf_reg, rf_data, edges);
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL lat_timeout: rf_wen never rose within %0d edges, expected 1", edges);
        end else begin
            check("lat_edges", 100, 32'(edges), 32'd1);
            check("lat_rf_reg", 100, 32'(rf_reg), 32'hE);
            check("lat_rf_data", 100, 32'(rf_data), 32'hCAFE);
        end
        @(posedge clk);
        #1;
        check("lat_wen_drop", 101, 32'(rf_wen), 32'd0);
        check("lat_pend1_clear", 101, 32'(pend1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
